irq_gateway_arbiter: RTL and testbench
======================================

Name: irq_gateway_arbiter

Overview:
- Lightweight platform-level interrupt controller core that sits between the raw interrupt lines (UART, SPI, Ethernet, generic irq_i[29:7]) and the per-hart interrupt outputs (M and S context per core).
- Per-source gateway latches requests, then a per-target priority arbiter drives the irq line and the claim/complete handshake.
- Register state is written through a simple config port; the AXI front-end lives elsewhere.

Parameters:
- NUM_SRC, 30, number of interrupt sources including reserved ID 0; ID 0 is never pending.
- PRIO_W, 3, priority width; priority 0 means never interrupt.
- NR_CORES, 1, number of harts; targets NUM_TGT = 2*NR_CORES (even = M, odd = S).
- ID_W, $clog2(NUM_SRC), source ID width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- irq_src_i  in  NUM_SRC  level interrupt inputs, already synchronous to aclk; bit 0 ignored.
- cfg_we_i  in  1  config write strobe.
- cfg_sel_i  in  2  0 = source priority, 1 = target enable bit, 2 = target threshold.
- cfg_src_i  in  ID_W  source index (sel 0/1).
- cfg_tgt_i  in  $clog2(NUM_TGT)  target index (sel 1/2).
- cfg_wdata_i  in  PRIO_W  priority, threshold, or enable in bit 0.
- claim_req_i  in  NUM_TGT  one-cycle claim pulse per target.
- claim_id_o  out  NUM_TGT*ID_W  claimed ID, valid the cycle after claim_req_i; 0 = none.
- complete_req_i  in  NUM_TGT  one-cycle complete pulse per target.
- complete_id_i  in  NUM_TGT*ID_W  ID being completed.
- irq_o  out  NUM_TGT  interrupt request per target context.

Behaviour:
- Reset (async assert, sync release): all priorities, enables, thresholds, pending and in_flight bits = 0; irq_o = 0; claim_id_o = 0.
- Gateway per source s≥1: pending[s] set on the rising aclk where irq_src_i[s]=1, pending[s]=0 and in_flight[s]=0. Claim clears pending and sets in_flight in the same edge. A completion whose ID matches an in_flight source clears in_flight; otherwise it is ignored.
- The gateway is level-sensitive. A source held high is re-pended the cycle after its completion.
- Arbiter per target t: candidate = pending & enable[t] & (prio>0). Pick the max priority; ties go to the lowest ID. best_id[t] and best_prio[t] are registered, so there is 1-cycle latency from a pending/config change to irq_o.
- irq_o[t] = (best_prio[t] > threshold[t]), registered.
- Claim: claim_req_i[t] captures the current registered best_id[t] into claim_id_o[t] on the next edge.
  - If best_prio[t] ≤ threshold[t], claim_id_o[t] is also 0.
  - claim_id_o holds until the next claim.
- Simultaneous claims of the same ID by several targets: the lowest target index gets the ID; the others get 0. The arbiter re-evaluates the next cycle.
- Claim and complete of the same ID in one cycle: claim wins, so in_flight ends set. A completion targets a previous claim only.
- A config write takes effect on the edge. An arbitration using the old value in the same cycle is permitted. Out-of-range cfg_src_i/cfg_tgt_i writes are dropped.
- Priority change to 0 for a pending source: the source stays pending but is excluded from candidates.
- Disabling a source does not clear pending.

Decomposition:
- Package irq_arb_pkg: cfg_sel enum (CFG_PRIO, CFG_EN, CFG_THRESH), prio_t, id_t, localparam reserved ID 0.
- Sub-module irq_prio_tree: a parameterised combinational max-priority/lowest-ID reduction tree, instantiated once per target.
- Gateway and claim logic stay in the top level.

Test Plan:
- Reset values: assert aresetn low mid-run with pending set → irq_o=0, claim_id_o=0, all state cleared; after release, no irq until sources are re-enabled.
- Basic path: prio[5]=3, en[t0][5]=1, thr[t0]=0, raise irq_src_i[5] → irq_o[0]=1 two edges later; claim → claim_id_o[0]=5, irq_o[0]=0 next cycle; complete 5 with the line still high → re-pend, irq_o[0]=1 again.
- Priority and tie-break: prio[3]=2, prio[7]=6, prio[9]=6, all pending → claims return 7, then 9, then 3.
- Threshold: prio[4]=2, thr[t1]=2 → irq_o[1]=0 and a claim returns 0; write thr=1 → irq_o[1]=1.
- Claim race: source 8 enabled for t0 and t1, both claim in the same cycle → t0 gets 8, t1 gets 0.
- Bogus complete: complete ID 12 that was never claimed → no state change. Complete 0 → ignored.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// Shared types and constants for the interrupt gateway/arbiter.
//   cfg_sel_e : decode of the config port select field
//   prio_t    : priority value at the default priority width
//   id_t      : source ID at the default source count
//   ID_RSVD   : reserved source ID that never becomes pending
package irq_arb_pkg;

    localparam int unsigned NUM_SRC_DEF = 30;
    localparam int unsigned PRIO_W_DEF  = 3;
    localparam int unsigned ID_W_DEF    = $clog2(NUM_SRC_DEF);
    localparam int unsigned ID_RSVD     = 0;

    typedef enum logic [1:0] {
        CFG_PRIO   = 2'd0,
        CFG_EN     = 2'd1,
        CFG_THRESH = 2'd2
    } cfg_sel_e;

    typedef logic [PRIO_W_DEF-1:0] prio_t;
    typedef logic [ID_W_DEF-1:0]   id_t;

endpackage

// File: rtl/irq_prio_tree.sv
// Combinational max-priority reduction tree.
//   cand_i : candidate mask, one bit per source
//   prio_i : priority of each source
//   id_o   : winning source (highest priority, lowest ID on ties), 0 if none
//   prio_o : priority of the winner, 0 if none
module irq_prio_tree #(
    parameter int unsigned N      = 30,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned ID_W   = 5
) (
    input  logic [N-1:0]             cand_i,
    input  logic [N-1:0][PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]          id_o,
    output logic [PRIO_W-1:0]        prio_o
);

    localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LEAVES = 1 << LEVELS;

    logic [LEAVES-1:0][PRIO_W-1:0] node_prio;
    logic [LEAVES-1:0][ID_W-1:0]   node_id;

    always_comb begin
        node_prio = '0;
        node_id   = '0;
        // Non-candidates and padding leaves carry priority 0 / ID 0 and can never win.
        for (int unsigned i = 0; i < N; i++) begin
            if (cand_i[i] && (prio_i[i] != '0)) begin
                node_prio[i] = prio_i[i];
                node_id[i]   = ID_W'(i);
            end
        end
        // Reduce pairs in place; node j reads 2j/2j+1, which are not yet overwritten.
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            for (int unsigned j = 0; j < (LEAVES >> (lvl + 1)); j++) begin
                // The left node always covers lower IDs, so it takes ties.
                if (node_prio[2*j] >= node_prio[2*j+1]) begin
                    node_prio[j] = node_prio[2*j];
                    node_id[j]   = node_id[2*j];
                end else begin
                    node_prio[j] = node_prio[2*j+1];
                    node_id[j]   = node_id[2*j+1];
                end
            end
        end
    end

    assign id_o   = node_id[0];
    assign prio_o = node_prio[0];

endmodule

// File: rtl/irq_gateway_arbiter.sv
// Interrupt controller core: per-source level gateways, per-target priority
// arbitration and the claim/complete handshake.
//   aclk, aresetn          : clock, asynchronous active-low reset
//   irq_src_i              : level interrupt lines (bit 0 ignored)
//   cfg_we_i/sel/src/tgt/wdata : config write port (priority, enable, threshold)
//   claim_req_i, claim_id_o    : per-target claim pulse and claimed ID (0 = none)
//   complete_req_i, complete_id_i : per-target completion pulse and ID
//   irq_o                  : interrupt request per target context
module irq_gateway_arbiter
    import irq_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC  = NUM_SRC_DEF,
    parameter int unsigned PRIO_W   = PRIO_W_DEF,
    parameter int unsigned NR_CORES = 1,
    parameter int unsigned ID_W     = $clog2(NUM_SRC)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_SRC-1:0]            irq_src_i,
    input  logic                          cfg_we_i,
    input  logic [1:0]                    cfg_sel_i,
    input  logic [ID_W-1:0]               cfg_src_i,
    input  logic [$clog2(2*NR_CORES)-1:0] cfg_tgt_i,
    input  logic [PRIO_W-1:0]             cfg_wdata_i,
    input  logic [2*NR_CORES-1:0]         claim_req_i,
    output logic [2*NR_CORES*ID_W-1:0]    claim_id_o,
    input  logic [2*NR_CORES-1:0]         complete_req_i,
    input  logic [2*NR_CORES*ID_W-1:0]    complete_id_i,
    output logic [2*NR_CORES-1:0]         irq_o
);

    localparam int unsigned NUM_TGT = 2 * NR_CORES;

    logic [NUM_SRC-1:0]              pend_q, pend_d, infl_q, infl_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0]  prio_q, prio_d;
    logic [NUM_TGT-1:0][NUM_SRC-1:0] en_q, en_d;
    logic [NUM_TGT-1:0][PRIO_W-1:0]  thr_q, thr_d;
    logic [NUM_TGT-1:0][ID_W-1:0]    best_id_q, best_id_d;
    logic [NUM_TGT-1:0][PRIO_W-1:0]  best_prio_q, best_prio_d;
    logic [NUM_TGT-1:0][ID_W-1:0]    claim_id_q, claim_id_d;
    logic [NUM_TGT-1:0][ID_W-1:0]    cmpl_id;
    logic [NUM_SRC-1:0]              prio_nz;
    logic [NUM_SRC-1:0]              taken;

    assign cmpl_id    = complete_id_i;
    assign claim_id_o = claim_id_q;

    always_comb begin
        prio_nz = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            prio_nz[s] = (prio_q[s] != '0);
        end
    end

    for (genvar t = 0; t < NUM_TGT; t++) begin : g_tgt
        irq_prio_tree #(
            .N      (NUM_SRC),
            .PRIO_W (PRIO_W),
            .ID_W   (ID_W)
        ) u_tree (
            .cand_i (pend_q & en_q[t] & prio_nz),
            .prio_i (prio_q),
            .id_o   (best_id_d[t]),
            .prio_o (best_prio_d[t])
        );
    end

    always_comb begin
        irq_o = '0;
        for (int unsigned t = 0; t < NUM_TGT; t++) begin
            irq_o[t] = (best_prio_q[t] > thr_q[t]);
        end
    end

    always_comb begin
        prio_d     = prio_q;
        en_d       = en_q;
        thr_d      = thr_q;
        claim_id_d = claim_id_q;
        taken      = '0;
        infl_d     = infl_q;

        // Level gateway: a line re-pends only once neither pending nor in flight.
        pend_d          = pend_q | (irq_src_i & ~pend_q & ~infl_q);
        pend_d[ID_RSVD] = 1'b0;

        for (int unsigned t = 0; t < NUM_TGT; t++) begin
            if (complete_req_i[t]) begin
                for (int unsigned s = 1; s < NUM_SRC; s++) begin
                    if (cmpl_id[t] == ID_W'(s)) begin
                        infl_d[s] = 1'b0;
                    end
                end
            end
        end

        // Claims are evaluated after completions so a same-cycle claim wins.
        // Lower target indices are visited first and take contested IDs; the
        // pending check keeps a stale best_id from being handed out twice.
        for (int unsigned t = 0; t < NUM_TGT; t++) begin
            if (claim_req_i[t]) begin
                claim_id_d[t] = '0;
                if (irq_o[t]) begin
                    for (int unsigned s = 1; s < NUM_SRC; s++) begin
                        if ((best_id_q[t] == ID_W'(s)) && pend_q[s] && !taken[s]) begin
                            claim_id_d[t] = ID_W'(s);
                            taken[s]      = 1'b1;
                            pend_d[s]     = 1'b0;
                            infl_d[s]     = 1'b1;
                        end
                    end
                end
            end
        end

        if (cfg_we_i) begin
            case (cfg_sel_e'(cfg_sel_i))
                CFG_PRIO: begin
                    if (32'(cfg_src_i) < NUM_SRC) prio_d[cfg_src_i] = cfg_wdata_i;
                end
                CFG_EN: begin
                    if ((32'(cfg_src_i) < NUM_SRC) && (32'(cfg_tgt_i) < NUM_TGT)) begin
                        en_d[cfg_tgt_i][cfg_src_i] = cfg_wdata_i[0];
                    end
                end
                CFG_THRESH: begin
                    if (32'(cfg_tgt_i) < NUM_TGT) thr_d[cfg_tgt_i] = cfg_wdata_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q      <= '0;
            infl_q      <= '0;
            prio_q      <= '0;
            en_q        <= '0;
            thr_q       <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            claim_id_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            infl_q      <= infl_d;
            prio_q      <= prio_d;
            en_q        <= en_d;
            thr_q       <= thr_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            claim_id_q  <= claim_id_d;
        end
    end

endmodule

// File: tb/tb_irq_gateway_arbiter.sv
// Self-checking bench for irq_gateway_arbiter (30 sources, 2 targets).
module tb_irq_gateway_arbiter;
    import irq_arb_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic [29:0] irq_src;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [4:0]  cfg_src;
    logic [0:0]  cfg_tgt;
    logic [2:0]  cfg_wdata;
    logic [1:0]  claim_req;
    logic [9:0]  claim_id;
    logic [1:0]  complete_req;
    logic [9:0]  complete_id;
    logic [1:0]  irq;

    int n_pass  = 0;
    int n_total = 0;

    irq_gateway_arbiter dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .irq_src_i      (irq_src),
        .cfg_we_i       (cfg_we),
        .cfg_sel_i      (cfg_sel),
        .cfg_src_i      (cfg_src),
        .cfg_tgt_i      (cfg_tgt),
        .cfg_wdata_i    (cfg_wdata),
        .claim_req_i    (claim_req),
        .claim_id_o     (claim_id),
        .complete_req_i (complete_req),
        .complete_id_i  (complete_id),
        .irq_o          (irq)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic [29:0] src;
        logic [1:0]  clm;
        logic [1:0]  cmp;
        logic [9:0]  cid;
        logic [1:0]  eirq;
        logic [9:0]  eclm;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [29:0] src, input logic [1:0] clm,
                                input logic [1:0] cmp, input logic [9:0] cid,
                                input logic [1:0] eirq, input logic [9:0] eclm);
        vec_t v;
        v.src = src; v.clm = clm; v.cmp = cmp; v.cid = cid; v.eirq = eirq; v.eclm = eclm;
        return v;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h, required %0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [4:0] src, input logic [0:0] tgt,
                             input logic [2:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_src = src; cfg_tgt = tgt; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_claim(input logic [1:0] mask);
        claim_req = mask;
        tick();
        claim_req = 2'b00;
    endtask

    task automatic do_complete(input int t, input logic [4:0] id);
        complete_req    = 2'b00;
        complete_req[t] = 1'b1;
        complete_id[t*5 +: 5] = id;
        tick();
        complete_req = 2'b00;
        complete_id  = '0;
    endtask

    localparam logic [29:0] S5 = 30'h20;

    initial begin
        aresetn = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_src = '0;
        cfg_tgt = '0; cfg_wdata = '0; claim_req = '0; complete_req = '0; complete_id = '0;

        // Basic path: raise, claim, complete with the line high, re-pend, idle claim, bogus IDs.
        vecs[0]  = mk(S5,    2'b00, 2'b00, 10'd0,  2'b00, 10'd0);
        vecs[1]  = mk(S5,    2'b00, 2'b00, 10'd0,  2'b01, 10'd0);
        vecs[2]  = mk(S5,    2'b01, 2'b00, 10'd0,  2'b01, 10'd5);
        vecs[3]  = mk(S5,    2'b00, 2'b00, 10'd0,  2'b00, 10'd5);
        vecs[4]  = mk(S5,    2'b00, 2'b01, 10'd5,  2'b00, 10'd5);
        vecs[5]  = mk(S5,    2'b00, 2'b00, 10'd0,  2'b00, 10'd5);
        vecs[6]  = mk(S5,    2'b00, 2'b00, 10'd0,  2'b01, 10'd5);
        vecs[7]  = mk(30'h0, 2'b01, 2'b00, 10'd0,  2'b01, 10'd5);
        vecs[8]  = mk(30'h0, 2'b00, 2'b01, 10'd5,  2'b00, 10'd5);
        vecs[9]  = mk(30'h0, 2'b01, 2'b00, 10'd0,  2'b00, 10'd0);
        vecs[10] = mk(30'h0, 2'b00, 2'b01, 10'd12, 2'b00, 10'd0);

        repeat (2) tick();
        check("reset irq", 32'(irq), 32'd0);
        check("reset claim_id", 32'(claim_id), 32'd0);
        aresetn = 1'b1;
        tick();

        cfg_write(CFG_PRIO, 5'd5, 1'b0, 3'd3);
        cfg_write(CFG_EN, 5'd5, 1'b0, 3'd1);
        cfg_write(CFG_THRESH, 5'd0, 1'b0, 3'd0);
        for (int i = 0; i < 11; i++) begin
            irq_src = vecs[i].src; claim_req = vecs[i].clm;
            complete_req = vecs[i].cmp; complete_id = vecs[i].cid;
            tick();
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].eirq));
            check($sformatf("vec%0d claim_id", i), 32'(claim_id), 32'(vecs[i].eclm));
        end
        irq_src = '0; claim_req = '0; complete_req = '0; complete_id = '0;

        // Priority order with tie-break on lowest ID.
        cfg_write(CFG_PRIO, 5'd3, 1'b0, 3'd2);
        cfg_write(CFG_PRIO, 5'd7, 1'b0, 3'd6);
        cfg_write(CFG_PRIO, 5'd9, 1'b0, 3'd6);
        cfg_write(CFG_EN, 5'd3, 1'b0, 3'd1);
        cfg_write(CFG_EN, 5'd7, 1'b0, 3'd1);
        cfg_write(CFG_EN, 5'd9, 1'b0, 3'd1);
        irq_src = 30'h288;
        tick(); tick();
        do_claim(2'b01); check("tie claim 1st", 32'(claim_id[4:0]), 32'd7); tick();
        do_claim(2'b01); check("tie claim 2nd", 32'(claim_id[4:0]), 32'd9); tick();
        do_claim(2'b01); check("tie claim 3rd", 32'(claim_id[4:0]), 32'd3); tick();
        check("tie all claimed irq", 32'(irq), 32'd0);
        irq_src = '0;
        do_complete(0, 5'd7); do_complete(0, 5'd9); do_complete(0, 5'd3);

        // Threshold on target 1.
        cfg_write(CFG_PRIO, 5'd4, 1'b0, 3'd2);
        cfg_write(CFG_EN, 5'd4, 1'b1, 3'd1);
        cfg_write(CFG_THRESH, 5'd0, 1'b1, 3'd2);
        irq_src = 30'h10;
        tick(); tick();
        check("thr equal irq", 32'(irq), 32'd0);
        do_claim(2'b10);
        check("thr equal claim", 32'(claim_id[9:5]), 32'd0);
        cfg_write(CFG_THRESH, 5'd0, 1'b1, 3'd1);
        check("thr lowered irq", 32'(irq), 32'd2);
        do_claim(2'b10);
        check("thr lowered claim", 32'(claim_id[9:5]), 32'd4);
        irq_src = '0;
        tick();
        do_complete(1, 5'd4);
        tick();

        // Claim race: both targets want source 8.
        cfg_write(CFG_PRIO, 5'd8, 1'b0, 3'd5);
        cfg_write(CFG_EN, 5'd8, 1'b0, 3'd1);
        cfg_write(CFG_EN, 5'd8, 1'b1, 3'd1);
        irq_src = 30'h100;
        tick(); tick();
        check("race both irq", 32'(irq), 32'd3);
        do_claim(2'b11);
        check("race t0 claim", 32'(claim_id[4:0]), 32'd8);
        check("race t1 claim", 32'(claim_id[9:5]), 32'd0);
        tick();
        check("race settled irq", 32'(irq), 32'd0);

        // Bogus completions leave source 8 in flight; the real one re-pends it.
        do_complete(0, 5'd12);
        do_complete(1, 5'd0);
        tick(); tick();
        check("bogus complete irq", 32'(irq), 32'd0);
        do_complete(0, 5'd8);
        tick(); tick();
        check("repend after complete", 32'(irq), 32'd3);

        // Priority 0 masks a pending source without dropping it.
        cfg_write(CFG_PRIO, 5'd8, 1'b0, 3'd0);
        tick();
        check("prio0 masked irq", 32'(irq), 32'd0);
        cfg_write(CFG_PRIO, 5'd8, 1'b0, 3'd5);
        tick();
        check("prio restored irq", 32'(irq), 32'd3);

        // Out-of-range source write must not disturb anything.
        cfg_write(CFG_PRIO, 5'd31, 1'b0, 3'd7);
        check("oor write irq", 32'(irq), 32'd3);

        // Asynchronous reset mid-run with a source pending.
        aresetn = 1'b0;
        #1;
        check("midrun reset irq", 32'(irq), 32'd0);
        check("midrun reset claim_id", 32'(claim_id), 32'd0);
        tick();
        aresetn = 1'b1;
        tick(); tick(); tick();
        check("post reset no irq", 32'(irq), 32'd0);
        cfg_write(CFG_PRIO, 5'd8, 1'b0, 3'd1);
        cfg_write(CFG_EN, 5'd8, 1'b0, 3'd1);
        tick();
        check("post reset reenabled irq", 32'(irq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
